uart_rx: RTL and testbench

UART receiver, the inbound counterpart of UART_TX in the USB-UART bridge. It takes the serial line from the USB-UART bridge chip and reassembles 8N1 frames into bytes, using a 16x oversample tick from the baud generator. Completed bytes sit in a one-deep holding register with a valid/ack handshake toward the parallel consumer, for example the loopback path into UART_TX. Framing and overrun errors are flagged per event.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 45 ++++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and defaults for the USB-UART bridge (RX, TX and
//             baud generator).
//  Contents : UART_OVERSAMPLE / UART_DATA_BITS default constants,
//             rx_state_t receiver state encoding, majority3 vote helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // 2-of-3 vote used to reject single-sample noise on the serial line.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Purpose  : Brings the asynchronous serial line into the sys_clk domain and
//             produces a noise-filtered bit value at the oversample rate.
//  Ports    : sys_clk        - system clock
//             reset          - asynchronous active-high reset
//             RxD_ser        - raw serial line (idle high)
//             OversampleTick - one-cycle strobe at OVERSAMPLE x baud
//             rx_bit         - majority of the last three tick samples
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic RxD_ser,
  input  logic OversampleTick,
  output logic rx_bit
);

  logic [SYNC_STAGES-1:0] r_syncChain;
  logic [2:0]             r_samples;

  // Both the synchroniser and the vote window reset to the idle (high) level
  // so that a reset never looks like a start bit.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_syncChain <= '1;
      r_samples   <= '1;
    end else begin
      r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], RxD_ser};
      if (OversampleTick) begin
        r_samples <= {r_samples[1:0], r_syncChain[SYNC_STAGES-1]};
      end
    end
  end

  assign rx_bit = majority3(r_samples);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with 16x oversampling, one-deep holding
//             register and valid/ack handshake toward the parallel consumer.
//  Ports    : sys_clk        - system clock (27 MHz nominal)
//             reset          - asynchronous active-high reset
//             RxD_ser        - serial line, asynchronous, idle high
//             OversampleTick - one-cycle strobe at OVERSAMPLE x baud
//             RxD_par        - received byte, stable while RxD_valid
//             RxD_valid      - holding register full
//             RxD_ack        - consumer takes the byte (only when valid)
//             RxD_busy       - a frame is in progress
//             frame_err      - one-cycle pulse, stop bit sampled low
//             overrun        - one-cycle pulse, good frame dropped (reg full)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 RxD_ser,
  input  logic                 OversampleTick,
  output logic [DATA_BITS-1:0] RxD_par,
  output logic                 RxD_valid,
  input  logic                 RxD_ack,
  output logic                 RxD_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int c_TICK_W = $clog2(OVERSAMPLE);
  localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [c_TICK_W-1:0] c_HALF_TICK = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_LAST_TICK = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);

  if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_badOversample
    $error("uart_rx: OVERSAMPLE must be even and at least 8");
  end

  if (SYNC_STAGES < 2) begin : g_badSyncStages
    $error("uart_rx: SYNC_STAGES must be at least 2");
  end

  rx_state_t             r_state;
  logic [c_TICK_W-1:0]   r_tickCnt;
  logic [c_BIT_W-1:0]    r_bitCnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  w_rxBit;
  logic                  w_frameGood;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .RxD_ser        (RxD_ser),
    .OversampleTick (OversampleTick),
    .rx_bit         (w_rxBit)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM. State and counters only move on oversample ticks; the pulse
  // output frame_err is cleared every sys_clk so it stays one cycle wide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tickCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      RxD_busy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (OversampleTick) begin
        case (r_state)
          IDLE: begin
            if (!w_rxBit) begin
              r_state   <= START;
              r_tickCnt <= '0;
              RxD_busy  <= 1'b1;
            end
          end

          START: begin
            if (r_tickCnt == c_HALF_TICK) begin
              r_tickCnt <= '0;
              if (w_rxBit) begin
                // Line went back high before mid start bit: a glitch.
                r_state  <= IDLE;
                RxD_busy <= 1'b0;
              end else begin
                r_state  <= DATA;
                r_bitCnt <= '0;
              end
            end else begin
              r_tickCnt <= r_tickCnt + 1'b1;
            end
          end

          DATA: begin
            if (r_tickCnt == c_LAST_TICK) begin
              r_tickCnt <= '0;
              // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
              r_shift   <= {w_rxBit, r_shift[DATA_BITS-1:1]};
              r_bitCnt  <= r_bitCnt + 1'b1;
              if (r_bitCnt == c_LAST_BIT) begin
                r_state <= STOP;
              end
            end else begin
              r_tickCnt <= r_tickCnt + 1'b1;
            end
          end

          STOP: begin
            if (r_tickCnt == c_LAST_TICK) begin
              r_tickCnt <= '0;
              if (w_rxBit) begin
                // Leaving at stop centre lets the next start edge be caught
                // half a bit early, absorbing baud mismatch.
                r_state  <= IDLE;
                RxD_busy <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                r_state   <= BREAK;
              end
            end else begin
              r_tickCnt <= r_tickCnt + 1'b1;
            end
          end

          BREAK: begin
            // Hold here until the line idles so a long break reports once.
            if (w_rxBit) begin
              r_state  <= IDLE;
              RxD_busy <= 1'b0;
            end
          end

          default: begin
            r_state  <= IDLE;
            RxD_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_frameGood = OversampleTick && (r_state == STOP) &&
                       (r_tickCnt == c_LAST_TICK) && w_rxBit;

  // ---------------------------------------------------------------------------
  // Holding register and handshake, evaluated every sys_clk. An ack arriving
  // with a new byte frees the slot in the same cycle, so no overrun is raised.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      RxD_par   <= '0;
      RxD_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_frameGood) begin
        if (!RxD_valid || RxD_ack) begin
          RxD_par   <= r_shift;
          RxD_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (RxD_valid && RxD_ack) begin
        RxD_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx: table of clean frames followed
//             by directed sequences for glitch, framing error, overrun,
//             simultaneous ack/load and mid-frame reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       RxD_ser = 1'b1;
  logic       OversampleTick = 1'b0;
  logic       RxD_ack = 1'b0;
  logic [7:0] RxD_par;
  logic       RxD_valid;
  logic       RxD_busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int feCnt  = 0;
  int ovCnt  = 0;
  int divCnt = 0;

  uart_rx #(
    .OVERSAMPLE  (16),
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .RxD_ser        (RxD_ser),
    .OversampleTick (OversampleTick),
    .RxD_par        (RxD_par),
    .RxD_valid      (RxD_valid),
    .RxD_ack        (RxD_ack),
    .RxD_busy       (RxD_busy),
    .frame_err      (frame_err),
    .overrun        (overrun)
  );

  // 37-unit clock period
  always begin
    #19 sys_clk = 1'b1;
    #18 sys_clk = 1'b0;
  end

  // Oversample strobe: one clock in every 15, changed on the falling edge.
  always @(negedge sys_clk) begin
    if (divCnt == 14) divCnt = 0;
    else divCnt = divCnt + 1;
    OversampleTick = (divCnt == 14);
  end

  // Pulse counters (each high cycle counts once).
  always @(negedge sys_clk) begin
    if (frame_err === 1'b1) feCnt = feCnt + 1;
    if (overrun === 1'b1) ovCnt = ovCnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] expPar;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitTick();
    @(posedge sys_clk);
    while (!OversampleTick) @(posedge sys_clk);
  endtask

  task automatic sendBit(input logic b, input int nTicks);
    @(negedge sys_clk);
    RxD_ser = b;
    repeat (nTicks) waitTick();
  endtask

  task automatic ackPulse();
    @(negedge sys_clk);
    RxD_ack = 1'b1;
    @(negedge sys_clk);
    RxD_ack = 1'b0;
  endtask

  // Idle gap, start bit, 8 data bits LSB first, then stop. With stopLow the
  // stop bit is held low for two bit times. With ackAtStop the ack is raised
  // exactly in the cycle the receiver delivers the byte: the stop centre is
  // sampled on the 11th tick into the stop bit (2 sync clocks + vote delay).
  task automatic sendFrame(input logic [7:0] d, input logic stopLow,
                           input logic ackAtStop, input logic [7:0] prevPar);
    sendBit(1'b1, 32);
    sendBit(1'b0, 16);
    for (int i = 0; i < 8; i++) sendBit(d[i], 16);
    if (stopLow) begin
      sendBit(1'b0, 32);
    end else if (ackAtStop) begin
      sendBit(1'b1, 10);
      repeat (14) @(posedge sys_clk);
      @(negedge sys_clk);
      check("ackLoadPreValid", RxD_valid, 1);
      check("ackLoadPrePar", RxD_par, prevPar);
      RxD_ack = 1'b1;
      @(negedge sys_clk);
      RxD_ack = 1'b0;
      check("ackLoadValid", RxD_valid, 1);
      check("ackLoadPar", RxD_par, d);
      check("ackLoadOverrun", overrun, 0);
      repeat (5) waitTick();
    end else begin
      sendBit(1'b1, 16);
    end
  endtask

  initial begin
    int fe0, ov0, busyClk;

    vecs[0] = '{8'h55, 8'h55};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h80, 8'h80};
    vecs[4] = '{8'h01, 8'h01};
    vecs[5] = '{8'hC3, 8'hC3};

    // Reset state
    #3 reset = 1'b1;
    #2;
    check("rstPar", RxD_par, 0);
    check("rstValid", RxD_valid, 0);
    check("rstBusy", RxD_busy, 0);
    check("rstFe", frame_err, 0);
    check("rstOv", overrun, 0);
    repeat (5) @(negedge sys_clk);
    reset = 1'b0;

    // Clean frames, ack held low then released
    for (int i = 0; i < 6; i++) begin
      fe0 = feCnt;
      ov0 = ovCnt;
      sendFrame(vecs[i].data, 1'b0, 1'b0, 8'h00);
      @(negedge sys_clk);
      check("vecValid", RxD_valid, 1);
      check("vecPar", RxD_par, vecs[i].expPar);
      check("vecBusy", RxD_busy, 0);
      repeat (200) @(negedge sys_clk);
      check("vecHeld", {RxD_valid, RxD_par}, {1'b1, vecs[i].expPar});
      check("vecNoFe", feCnt - fe0, 0);
      check("vecNoOv", ovCnt - ov0, 0);
      ackPulse();
      check("ackClears", RxD_valid, 0);
      check("parHolds", RxD_par, vecs[i].expPar);
      ackPulse();
      check("ackIgnored", RxD_valid, 0);
    end

    // Three-tick glitch on idle line: false start
    busyClk = 0;
    sendBit(1'b1, 32);
    sendBit(1'b0, 3);
    @(negedge sys_clk);
    RxD_ser = 1'b1;
    repeat (20 * 15) begin
      @(negedge sys_clk);
      if (RxD_busy) busyClk = busyClk + 1;
    end
    check("glitchBusySeen", busyClk > 0, 1);
    check("glitchBusyMax", busyClk <= 8 * 15, 1);
    check("glitchIdle", RxD_busy, 0);
    check("glitchNoValid", RxD_valid, 0);

    // Framing error with stop held low, then recovery
    fe0 = feCnt;
    sendFrame(8'hA3, 1'b1, 1'b0, 8'h00);
    sendBit(1'b1, 16);
    check("feCount", feCnt - fe0, 1);
    check("feNoValid", RxD_valid, 0);
    check("feBusyClear", RxD_busy, 0);
    sendFrame(8'h3C, 1'b0, 1'b0, 8'h00);
    @(negedge sys_clk);
    check("feRecoverValid", RxD_valid, 1);
    check("feRecoverPar", RxD_par, 8'h3C);
    check("feCountAfter", feCnt - fe0, 1);
    ackPulse();

    // Overrun: second frame dropped while first unacked
    ov0 = ovCnt;
    sendFrame(8'h11, 1'b0, 1'b0, 8'h00);
    sendFrame(8'h22, 1'b0, 1'b0, 8'h00);
    @(negedge sys_clk);
    check("ovPar", RxD_par, 8'h11);
    check("ovValid", RxD_valid, 1);
    check("ovCount", ovCnt - ov0, 1);
    ackPulse();
    check("ovAckClears", RxD_valid, 0);
    ov0 = ovCnt;
    sendFrame(8'h33, 1'b0, 1'b0, 8'h00);
    @(negedge sys_clk);
    check("ovNextPar", RxD_par, 8'h33);
    check("ovNextNoOv", ovCnt - ov0, 0);
    ackPulse();

    // Ack in the same cycle a new byte loads
    ov0 = ovCnt;
    sendFrame(8'h5A, 1'b0, 1'b0, 8'h00);
    sendFrame(8'h7E, 1'b0, 1'b1, 8'h5A);
    repeat (3) @(negedge sys_clk);
    check("simAckValid", RxD_valid, 1);
    check("simAckPar", RxD_par, 8'h7E);
    check("simAckNoOv", ovCnt - ov0, 0);

    // Reset in the middle of the data bits of 0xF0
    fe0 = feCnt;
    ov0 = ovCnt;
    sendBit(1'b1, 32);
    sendBit(1'b0, 16);
    sendBit(1'b0, 16);
    sendBit(1'b0, 16);
    @(negedge sys_clk);
    check("midBusy", RxD_busy, 1);
    #5 reset = 1'b1;
    #1;
    check("midRstPar", RxD_par, 0);
    check("midRstValid", RxD_valid, 0);
    check("midRstBusy", RxD_busy, 0);
    check("midRstFlags", {frame_err, overrun}, 0);
    RxD_ser = 1'b1;
    repeat (4) @(negedge sys_clk);
    reset = 1'b0;
    sendFrame(8'h0F, 1'b0, 1'b0, 8'h00);
    @(negedge sys_clk);
    check("postRstValid", RxD_valid, 1);
    check("postRstPar", RxD_par, 8'h0F);
    check("postRstNoFe", feCnt - fe0, 0);
    check("postRstNoOv", ovCnt - ov0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
